// File: rtl/vga_fb_arbiter.sv
// Framebuffer write-port arbiter. CPU bus writes and a rectangle-fill engine
// share one RAM write port. When both request in the same cycle, they take
// turns under a round-robin pointer. Fill writes that land outside the
// visible framebuffer still use their slot, but they do not assert the write
// enable.
module vga_fb_arbiter #(
  parameter int AW       = 15,
  parameter int DW       = 16,
  parameter int STRIDE   = 80,
  parameter int FB_WORDS = 9600
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_data,
  output logic          cpu_gnt,
  input  logic          fill_start,
  input  logic [AW-1:0] fill_base,
  input  logic [6:0]    fill_w,
  input  logic [6:0]    fill_h,
  input  logic [7:0]    fill_color,
  output logic          fill_busy,
  output logic          fill_done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [AW-1:0] STRIDE_W = AW'(STRIDE);
  localparam logic [AW-1:0] FB_LIM   = AW'(FB_WORDS);

  logic [1:0]    state;
  logic [AW-1:0] cur, row_base;
  logic [6:0]    col, row, lw, lh;
  logic [7:0]    lcolor;
  logic          prio_fill;   // 1: fill wins the next contended cycle
  logic          fill_req, fill_gnt, contended, fill_clip;
  logic [DW-1:0] fill_word;

  assign fill_req  = (state == S_RUN);
  assign contended = cpu_req & fill_req;
  assign cpu_gnt   = cpu_req  & (~fill_req | ~prio_fill);
  assign fill_gnt  = fill_req & (~cpu_req  |  prio_fill);
  assign fill_clip = (cur >= FB_LIM);
  assign fill_word = DW'({lcolor, lcolor});
  assign fill_busy = (state != S_IDLE);
  assign fill_done = (state == S_DONE);

  // Round-robin pointer: it flips only when both sides compete, so contended
  // cycles strictly alternate between CPU and fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         prio_fill <= 1'b0;
    else if (contended) prio_fill <= ~prio_fill;
  end

  // Registered write port. Address and data hold their values when no write is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else if (cpu_gnt) begin
      ram_we   <= 1'b1;
      ram_addr <= cpu_addr;
      ram_data <= cpu_data;
    end else if (fill_gnt && !fill_clip) begin
      ram_we   <= 1'b1;
      ram_addr <= cur;
      ram_data <= fill_word;
    end else begin
      ram_we   <= 1'b0;
    end
  end

  // Fill engine: walks the rectangle row by row and advances one word per granted slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur      <= '0;
      row_base <= '0;
      col      <= '0;
      row      <= '0;
      lw       <= '0;
      lh       <= '0;
      lcolor   <= '0;
    end else begin
      case (state)
        S_IDLE: if (fill_start) begin
          lw       <= fill_w;
          lh       <= fill_h;
          lcolor   <= fill_color;
          cur      <= fill_base;
          row_base <= fill_base;
          col      <= '0;
          row      <= '0;
          state    <= (fill_w == 7'd0 || fill_h == 7'd0) ? S_DONE : S_RUN;
        end
        S_RUN: if (fill_gnt) begin
          if (col != lw - 7'd1) begin
            col <= col + 7'd1;
            cur <= cur + 1'b1;
          end else if (row != lh - 7'd1) begin
            col      <= '0;
            row      <= row + 7'd1;
            row_base <= row_base + STRIDE_W;
            cur      <= row_base + STRIDE_W;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter. Expected RAM writes are queued when stimulus is
// driven. A negedge monitor pops the queue and compares each write the DUT
// issues. Fill vectors come from a table. The CPU timing, a fill_start while
// busy and a reset during a fill are covered by hand-written sequences.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_data;
  logic        cpu_gnt;
  logic        fill_start;
  logic [14:0] fill_base;
  logic [6:0]  fill_w, fill_h;
  logic [7:0]  fill_color;
  logic        fill_busy, fill_done;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_data;

  vga_fb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_gnt(cpu_gnt),
    .fill_start(fill_start), .fill_base(fill_base), .fill_w(fill_w), .fill_h(fill_h),
    .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] base;
    logic [6:0]  w, h;
    logic [7:0]  color;
    int          ncpu;
    int          cpu_dly;
    int          exp_nwr;
  } vec_t;

  vec_t        tbl[9];
  logic [30:0] exp_cpu[$];
  logic [30:0] exp_fill[$];
  bit          src_log[$];   // 0 = CPU write, 1 = fill write
  int          checks = 0, errors = 0, wr_cnt = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: each enabled write must match the head of the CPU queue or the fill queue.
  always @(negedge clk) begin
    if (rst_n && ram_we) begin
      wr_cnt++;
      checks++;
      if (exp_cpu.size() > 0 && exp_cpu[0] == {ram_addr, ram_data}) begin
        void'(exp_cpu.pop_front());
        src_log.push_back(1'b0);
      end else if (exp_fill.size() > 0) begin
        logic [30:0] e;
        e = exp_fill.pop_front();
        src_log.push_back(1'b1);
        if (e != {ram_addr, ram_data}) begin
          errors++;
          $display("FAIL write: got %h/%h expected %h/%h", ram_addr, ram_data, e[30:16], e[15:0]);
        end
      end else begin
        errors++;
        $display("FAIL write: unexpected %h/%h", ram_addr, ram_data);
      end
    end
  end

  // Reference model: visits the rectangle in raster order and drops clipped words.
  task automatic push_fill(input logic [14:0] b, input int w, input int h, input logic [7:0] c);
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++) begin
        int a;
        a = (int'(b) + r * 80 + k) % 32768;
        if (a < 9600) exp_fill.push_back({a[14:0], c, c});
      end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
    fill_start = 1'b0; fill_base = '0; fill_w = '0; fill_h = '0; fill_color = '0;
    exp_cpu.delete(); exp_fill.delete(); src_log.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_fill(input vec_t v, output int bc, output int dc);
    bit seen = 0, fin = 0;
    bc = 0; dc = 0;
    fill_base = v.base; fill_w = v.w; fill_h = v.h; fill_color = v.color;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int t = 0; t < 20000; t++) begin
      @(negedge clk);
      if (fill_busy) bc++;
      if (fill_done) begin dc++; seen = 1; end
      else if (seen && !fill_busy) begin fin = 1; break; end
    end
    if (!fin) chk("fill_timeout", 0, 1);
    tick();
  endtask

  task automatic cpu_writes(input int n, input int dly);
    if (n == 0) return;
    repeat (dly) tick();
    for (int i = 0; i < n; i++) begin
      bit got = 0;
      cpu_req = 1'b1; cpu_addr = 15'h0100 + 15'(i); cpu_data = 16'hC000 + 16'(i);
      for (int t = 0; t < 20000 && !got; t++) begin
        @(negedge clk);
        if (cpu_gnt) begin exp_cpu.push_back({cpu_addr, cpu_data}); got = 1; end
        @(posedge clk); #1;
      end
      if (!got) chk("cpu_gnt_timeout", 0, 1);
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    int w0, bc, dc;
    tbl[0] = '{15'd0,     7'd2,  7'd2,   8'h5A, 0, 1, 4};
    tbl[1] = '{15'd0,     7'd2,  7'd2,   8'h5A, 4, 1, 8};
    tbl[2] = '{15'd9599,  7'd2,  7'd1,   8'h33, 0, 1, 1};
    tbl[3] = '{15'd0,     7'd0,  7'd5,   8'h44, 0, 1, 0};
    tbl[4] = '{15'd100,   7'd3,  7'd3,   8'h11, 0, 1, 9};
    tbl[5] = '{15'd32760, 7'd10, 7'd2,   8'h22, 0, 1, 12};
    tbl[6] = '{15'd70,    7'd80, 7'd1,   8'h66, 3, 1, 83};
    tbl[7] = '{15'd500,   7'd3,  7'd1,   8'h99, 2, 0, 5};
    tbl[8] = '{15'd0,     7'd80, 7'd120, 8'h00, 0, 1, 9600};

    // Outputs while reset is asserted.
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
    fill_start = 1'b0; fill_base = '0; fill_w = '0; fill_h = '0; fill_color = '0;
    #12;
    chk("reset_we", ram_we, 0);
    chk("reset_addr", ram_addr, 0);
    chk("reset_data", ram_data, 0);
    chk("reset_busy", fill_busy, 0);
    chk("reset_done", fill_done, 0);

    // Single CPU write: granted in the same cycle, written one cycle later, then ram_we drops.
    do_reset();
    cpu_req = 1'b1; cpu_addr = 15'h0010; cpu_data = 16'hABCD;
    @(negedge clk);
    chk("cpu_gnt", cpu_gnt, 1);
    exp_cpu.push_back({15'h0010, 16'hABCD});
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("cpu_we", ram_we, 1);
    chk("cpu_addr", ram_addr, 15'h0010);
    chk("cpu_data", ram_data, 16'hABCD);
    @(negedge clk);
    chk("cpu_we_drop", ram_we, 0);
    tick();

    // Table-driven fills. Some run with concurrent CPU traffic.
    foreach (tbl[i]) begin
      do_reset();
      w0 = wr_cnt;
      push_fill(tbl[i].base, int'(tbl[i].w), int'(tbl[i].h), tbl[i].color);
      fork
        run_fill(tbl[i], bc, dc);
        cpu_writes(tbl[i].ncpu, tbl[i].cpu_dly);
      join
      repeat (3) tick();
      chk($sformatf("v%0d_done_pulses", i), dc, 1);
      chk($sformatf("v%0d_writes", i), wr_cnt - w0, tbl[i].exp_nwr);
      chk($sformatf("v%0d_fill_left", i), exp_fill.size(), 0);
      chk($sformatf("v%0d_cpu_left", i), exp_cpu.size(), 0);
      if (tbl[i].ncpu == 0)
        chk($sformatf("v%0d_busy_cycles", i), bc,
            (tbl[i].w == 0 || tbl[i].h == 0) ? 1 : int'(tbl[i].w) * int'(tbl[i].h) + 1);
      if (i == 1)
        for (int k = 0; k < 8; k++)
          chk($sformatf("alt_src%0d", k), (k < src_log.size()) ? src_log[k] : 2, k % 2);
    end

    // Zero-width fill: fill_done is high in the cycle right after the start.
    do_reset();
    w0 = wr_cnt;
    fill_w = 7'd0; fill_h = 7'd5; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    @(negedge clk);
    chk("w0_done", fill_done, 1);
    @(negedge clk);
    chk("w0_done_clear", fill_done, 0);
    chk("w0_busy_clear", fill_busy, 0);
    tick();
    chk("w0_no_writes", wr_cnt - w0, 0);

    // A fill_start during RUN is ignored, so the 3x3 fill issues exactly 9 writes.
    do_reset();
    w0 = wr_cnt;
    push_fill(15'd200, 3, 3, 8'hA5);
    fill_base = 15'd200; fill_w = 7'd3; fill_h = 7'd3; fill_color = 8'hA5; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick(); tick();
    fill_base = 15'd0; fill_w = 7'd5; fill_h = 7'd5; fill_color = 8'hFF; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int t = 0; t < 200 && fill_busy; t++) tick();
    repeat (3) tick();
    chk("restart_writes", wr_cnt - w0, 9);
    chk("restart_fill_left", exp_fill.size(), 0);

    // Reset during a fill, after 3 of 9 writes.
    do_reset();
    w0 = wr_cnt;
    push_fill(15'd300, 3, 3, 8'h77);
    fill_base = 15'd300; fill_w = 7'd3; fill_h = 7'd3; fill_color = 8'h77; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    for (int t = 0; t < 50 && (wr_cnt - w0) < 3; t++) @(negedge clk);
    chk("midrst_pre_writes", wr_cnt - w0, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we", ram_we, 0);
    chk("midrst_busy", fill_busy, 0);
    chk("midrst_done", fill_done, 0);
    exp_fill.delete();
    w0 = wr_cnt;
    tick(); tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("midrst_no_more_writes", wr_cnt - w0, 0);
    chk("midrst_idle", fill_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
